// File: rtl/dispatch_16_32bits.sv
// 1:16 write distributor: steers one 32-bit input word into one of sixteen
// holding registers, each with its own valid/ack handshake and an occupancy count.
module dispatch_16_32bits (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_select,
  input  logic [31:0] in_data,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic [31:0] out3,
  output logic [31:0] out4,
  output logic [31:0] out5,
  output logic [31:0] out6,
  output logic [31:0] out7,
  output logic [31:0] out8,
  output logic [31:0] out9,
  output logic [31:0] out10,
  output logic [31:0] out11,
  output logic [31:0] out12,
  output logic [31:0] out13,
  output logic [31:0] out14,
  output logic [31:0] out15,
  output logic [15:0] out_valid,
  input  logic [15:0] out_ack,
  output logic [4:0]  busy_count
);

  logic [31:0] slot_q [16];
  logic        accept;
  logic [15:0] valid_next;
  logic [4:0]  count_next;

  // A slot can take a new word if empty, or if its consumer drains it this same edge.
  assign in_ready = ~out_valid[in_select] | out_ack[in_select];
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_next = out_valid & ~out_ack;
    if (accept) valid_next[in_select] = 1'b1;
    count_next = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      count_next = count_next + 5'(valid_next[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 16; i++) slot_q[i] <= '0;
      out_valid  <= '0;
      busy_count <= '0;
    end else begin
      if (accept) slot_q[in_select] <= in_data;
      out_valid  <= valid_next;
      busy_count <= count_next;
    end
  end

  assign out0  = slot_q[0];
  assign out1  = slot_q[1];
  assign out2  = slot_q[2];
  assign out3  = slot_q[3];
  assign out4  = slot_q[4];
  assign out5  = slot_q[5];
  assign out6  = slot_q[6];
  assign out7  = slot_q[7];
  assign out8  = slot_q[8];
  assign out9  = slot_q[9];
  assign out10 = slot_q[10];
  assign out11 = slot_q[11];
  assign out12 = slot_q[12];
  assign out13 = slot_q[13];
  assign out14 = slot_q[14];
  assign out15 = slot_q[15];

endmodule

// File: doc/dispatch_16_32bits.md
DISPATCH_16_32BITS -- requirements
Module: dispatch_16_32bits

Interface
REQ-001 SHALL have one clock and a reset that is asynchronous and active-low; the ports are named clock and reset as elsewhere in the codebase.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 in_valid  input  1  producer presents a word this cycle.
REQ-005 in_ready  output  1  block can accept the presented word this cycle.
REQ-006 in_select  input  4  destination slot index, 0..15.
REQ-007 in_data  input  32  word to deliver.
REQ-008 out0..out15  output  32 each  per-slot holding registers.
REQ-009 out_valid  output  16  bit N set = outN holds an unconsumed word.
REQ-010 out_ack  input  16  bit N = consumer N takes outN this cycle.
REQ-011 busy_count  output  5  number of set out_valid bits, 0..16.

Function
REQ-012 SHALL be the write/distribute counterpart of the 16:1 32-bit read mux: one input word is steered to 1 of 16 registered outputs.
REQ-013 in_ready SHALL be combinational: ~out_valid[in_select] | out_ack[in_select].
REQ-014 Accept SHALL occur when in_valid & in_ready at a rising edge; on accept, out[in_select] <= in_data and out_valid[in_select] <= 1; latency 1 cycle (visible the cycle after accept).
REQ-015 Ack on slot N SHALL take effect when out_ack[N] & out_valid[N]; out_valid[N] <= 0 at that edge unless the same edge accepts into N.
REQ-016 Simultaneous ack and accept on the same slot SHALL keep out_valid[N] = 1 and load the new word (pass-through refill, no bubble).
REQ-017 out_ack[N] while out_valid[N] = 0 SHALL be ignored, with no state change.
REQ-018 Acks on multiple slots in one cycle SHALL all take effect; at most one accept per cycle.
REQ-019 outN data SHALL hold its value after ack; it changes only on accept into N or reset.
REQ-020 Accept into an occupied slot with no ack SHALL be impossible (in_ready = 0); the producer holds in_valid, in_select and in_data stable until accepted.
REQ-021 Non-selected slots SHALL be unaffected by an accept.
REQ-022 in_select and in_data SHALL be don't-care while in_valid = 0.
REQ-023 busy_count SHALL be registered and always equal popcount(out_valid) in the same cycle: +1 on accept into an empty slot, -1 per effective ack not refilled, net of both in one edge.
REQ-024 busy_count = 16 SHALL occur only with all slots full; in_ready is then 1 only if out_ack[in_select] = 1.

Reset
REQ-025 While reset = 0, SHALL force out0..out15 = 32'h0, out_valid = 16'h0000 and busy_count = 0, asynchronously and without waiting for a clock edge.
REQ-026 In-flight words SHALL be discarded when reset is asserted mid-operation; no accept or ack takes effect while reset = 0.
REQ-027 In the first cycle after reset deasserts, in_ready SHALL be 1 for any in_select.

Verification
REQ-028 Reset, then in_valid=1, sel=5, data=32'hDEADBEEF for one cycle -> next cycle out5=32'hDEADBEEF, out_valid=16'h0020, busy_count=1, in_ready(sel=5)=0.
REQ-029 Slot 5 full, present sel=5, data=32'h1 with no ack for 3 cycles -> in_ready=0, out5 unchanged; assert out_ack[5] -> same edge loads 32'h1, out_valid[5] stays 1, busy_count stays 1.
REQ-030 Fill slots 0..15 with data=N -> busy_count=16, out_valid=16'hFFFF, in_ready=0; then out_ack=16'h8001 -> busy_count=14, out_valid=16'h7FFE, out0=0, out15=15.
REQ-031 out_ack[3]=1 with slot 3 empty, busy_count=2 -> no change in out_valid or busy_count.
REQ-032 Slots 2 and 9 full, assert reset=0 between clock edges -> out_valid=0, busy_count=0, out2=out9=0 immediately; after release in_ready=1.
